// File: rtl/alu_arb_pkg.sv
// Shared constants for the round-robin ALU arbiter: FSM encoding, opcodes
// and the default datapath width.
package alu_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/alu_core.sv
// Combinational add/multiply unit. Results are kept to WIDTH bits, so any
// carry or upper product bits are dropped.
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Select sum or product, both evaluated at WIDTH bits (silent truncation).
  always_comb begin
    if (op == OP_MUL) y = a * b;
    else              y = a + b;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for one shared add/multiply ALU.
// One operation in flight: IDLE accepts, EXEC waits out the multiply
// latency, RESP holds the result until the owner takes it.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_data,
  output logic             busy,
  output logic             owner
);

  // MUL_CYCLES below 1 is treated as a single-cycle multiply.
  localparam int MUL_EFF = (MUL_CYCLES < 1) ? 1 : MUL_CYCLES;
  localparam int CNT_W   = (MUL_EFF > 1) ? $clog2(MUL_EFF) : 1;
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_EFF - 1);

  logic [1:0]       state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             sel;
  logic             accept;
  logic             resp_hs;
  logic [WIDTH-1:0] alu_y;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) sel = ~last_grant_q;
    else if (req1_valid)          sel = 1'b1;
  end

  assign req0_ready = (state_q == ST_IDLE) && req0_valid && !sel;
  assign req1_ready = (state_q == ST_IDLE) && req1_valid && sel;
  assign accept     = req0_ready || req1_ready;

  assign resp0_valid = (state_q == ST_RESP) && !owner_q;
  assign resp1_valid = (state_q == ST_RESP) && owner_q;
  assign resp0_data  = resp0_valid ? result_q : '0;
  assign resp1_data  = resp1_valid ? result_q : '0;
  assign resp_hs     = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);

  assign busy  = (state_q != ST_IDLE);
  assign owner = busy ? owner_q : 1'b0;

  // Next-state logic for the FSM, operand capture, multiply counter and grant history.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXEC;
          owner_d = sel;
          op_d    = sel ? req1_op : req0_op;
          a_d     = sel ? req1_a  : req0_a;
          b_d     = sel ? req1_b  : req0_b;
          cnt_d   = (op_d == OP_MUL) ? MUL_INIT : '0;
        end
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          result_d = alu_y;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_hs) begin
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; synchronous active-low reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
    end
  end

endmodule
